point_translator: RTL and testbench
===================================

Name: point_translator

Overview:
- Parametrised, pipelined 2-D point translator for the sprite/vector render path.
- Adds a per-axis signed offset to each incoming (x,y) point and clamps the result to screen bounds (or drops it, see Optional Feature).
- Offsets are loadable directly and also advance by a per-axis velocity on each frame tick, which supports animated motion.
- Sits between the point generator/rotation stage and the pixel/draw stage, with valid/ready flow control on both sides.

Parameters:
- COORD_W, 12, signed coordinate width of in_x/in_y/offsets.
- VEL_W, 5, signed velocity width.
- X_MAX, 1023, largest legal output x; output x range is 0..X_MAX.
- Y_MAX, 767, largest legal output y; output y range is 0..Y_MAX.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle strobe that advances offsets by velocity.
- load_offset  in  1  loads offset_x_in/offset_y_in into the offset registers.
- offset_x_in  in  COORD_W  signed x offset load value.
- offset_y_in  in  COORD_W  signed y offset load value.
- vel_x  in  VEL_W  signed x velocity per frame.
- vel_y  in  VEL_W  signed y velocity per frame.
- in_valid  in  1  input point valid.
- in_ready  out  1  translator can accept a point.
- in_x  in  COORD_W  signed input x.
- in_y  in  COORD_W  signed input y.
- out_valid  out  1  output point valid.
- out_ready  in  1  downstream accepts the output point.
- out_x  out  COORD_W  translated, clamped x (unsigned value, MSB 0).
- out_y  out  COORD_W  translated, clamped y.
- out_clipped  out  1  clamping occurred on either axis for this point.
- offset_x  out  COORD_W  current x offset register.
- offset_y  out  COORD_W  current y offset register.

Behaviour:
- Reset values: out_valid=0, out_x=0, out_y=0, out_clipped=0, offset_x=0, offset_y=0; both pipeline stages are empty.
- in_ready is held 0 while reset is asserted.
- Reset asserted mid-transfer discards any in-flight points; no output beat is produced for them.
- A point is accepted on a rising edge with in_valid && in_ready.
- Stage 1 registers sx = in_x + offset_x and sy = in_y + offset_y, computed at COORD_W+1 bits signed with no wrap. It uses the offset value present in the acceptance cycle.
- Stage 2 clamps each axis independently:
  - sum < 0 gives 0, with clip set.
  - sum > MAX gives MAX, with clip set.
  - otherwise passes through unchanged.
  - out_clipped = clip_x | clip_y.
- Latency is 2 cycles from acceptance to out_valid when out_ready is held high. Throughput is 1 point per cycle.
- Flow control:
  - s2_adv = !out_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv, which is combinational and introduces no bubble.
- While out_valid=1 && out_ready=0, out_x, out_y and out_clipped hold stable and no point is lost.
- Offset update is registered:
  - load_offset=1: offset takes *_in.
  - otherwise frame_tick=1: offset = sat(offset + sign-extended vel).
  - otherwise hold.
  - load_offset and frame_tick in the same cycle: load wins and velocity is ignored for that tick.
- Saturation limits are -2^(COORD_W-1) and 2^(COORD_W-1)-1 (defaults -2048 and 2047). Offsets never wrap.
- An offset change takes effect for points accepted on the following cycle. Points already in the pipe keep their original offset.

Optional Feature:
- Macro: POINT_TRANSLATOR_CLIP_DROP_EN.
- Defined: a point with either axis out of range is dropped in stage 2. No out_valid beat is produced, the slot frees as if consumed, and out_clipped is tied to 0.
- Undefined: the clamp-and-flag behaviour above.

Test Plan:
- Reset mid-stream with 2 points in flight -> out_valid=0 next edge, offsets=0, no stale beat after release, in_ready=1 once reset deasserts.
- Load offset (+100,-50), stream (10,60),(0,0) with out_ready=1 -> after 2 cycles out=(110,10) clip=0, then (100,0) clip=1.
- Offset (2040,0), vel_x=+15, 3 frame_ticks -> offset_x 2047 (saturated). Offset (-2040), vel_x=-16, 1 tick -> -2048.
- Point (1000,700), offset (+100,+100) -> out=(1023,767) clip=1. Point (-5,5), offset 0 -> out=(0,5) clip=1.
- Back-to-back 8 points, out_ready toggling 1,0,0,1,... -> all 8 delivered in order, held stable while stalled, in_ready low only when both stages are full and stalled.
- load_offset and frame_tick same cycle with load value 7, vel 3 -> offset=7. With CLIP_DROP_EN, point (-5,5) produces no output beat and the next valid point follows unaffected.

Source files
------------

// File: rtl/point_translator.sv
// point_translator: adds a per-axis signed offset to each (x,y) point and clamps to screen bounds.
// Two-stage pipeline (sum, then clamp); acceptance-to-out_valid latency is 2 cycles.
// Stages advance independently and in_ready is combinational, so one point per cycle flows without bubbles.
//
// Ports:
//   clk, reset              - clock, asynchronous active-high reset
//   frame_tick, load_offset - offset update controls (load has priority over tick)
//   offset_x_in/offset_y_in - signed offset load values
//   vel_x/vel_y             - signed per-frame velocity added on frame_tick, saturating
//   in_valid/in_ready       - input handshake for in_x/in_y (signed)
//   out_valid/out_ready     - output handshake for out_x/out_y (0..MAX) and out_clipped
//   offset_x/offset_y       - current offset registers
//
// Build option: POINT_TRANSLATOR_CLIP_DROP_EN
//   When defined, points outside the screen on either axis are dropped in stage 2 and out_clipped is 0.
module point_translator #(
  parameter int COORD_W = 12,
  parameter int VEL_W   = 5,
  parameter int X_MAX   = 1023,
  parameter int Y_MAX   = 767
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame_tick,
  input  logic                      load_offset,
  input  logic signed [COORD_W-1:0] offset_x_in,
  input  logic signed [COORD_W-1:0] offset_y_in,
  input  logic signed [VEL_W-1:0]   vel_x,
  input  logic signed [VEL_W-1:0]   vel_y,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [COORD_W-1:0] in_x,
  input  logic signed [COORD_W-1:0] in_y,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [COORD_W-1:0]        out_x,
  output logic [COORD_W-1:0]        out_y,
  output logic                      out_clipped,
  output logic signed [COORD_W-1:0] offset_x,
  output logic signed [COORD_W-1:0] offset_y
);

  localparam logic signed [COORD_W:0] L_XMAX = (COORD_W+1)'(X_MAX);
  localparam logic signed [COORD_W:0] L_YMAX = (COORD_W+1)'(Y_MAX);

  // Offset + velocity, evaluated one bit wider; an overflow into the extra bit
  // saturates to the most negative / most positive offset instead of wrapping.
  function automatic logic signed [COORD_W-1:0] sat_add(
    input logic signed [COORD_W-1:0] a,
    input logic signed [VEL_W-1:0]   v
  );
    logic signed [COORD_W:0] s;
    s = {a[COORD_W-1], a} + {{(COORD_W+1-VEL_W){v[VEL_W-1]}}, v};
    if (s[COORD_W] != s[COORD_W-1])
      sat_add = s[COORD_W] ? {1'b1, {(COORD_W-1){1'b0}}} : {1'b0, {(COORD_W-1){1'b1}}};
    else
      sat_add = s[COORD_W-1:0];
  endfunction

  logic signed [COORD_W-1:0] r_off_x, r_off_y;
  logic                      r_s1_vld;
  logic signed [COORD_W:0]   r_s1_x, r_s1_y;
  logic                      r_out_vld;
  logic [COORD_W-1:0]        r_out_x, r_out_y;
  logic                      r_out_clip;

  logic                      w_s2_adv, w_s1_adv;
  logic signed [COORD_W:0]   w_sum_x, w_sum_y;
  logic [COORD_W-1:0]        w_cx, w_cy;
  logic                      w_clip_x, w_clip_y, w_clip_out, w_s2_load;

  assign w_s2_adv = !r_out_vld || out_ready;
  assign w_s1_adv = !r_s1_vld || w_s2_adv;
  assign in_ready = w_s1_adv && !reset;

  // Sign-extended sums cannot overflow COORD_W+1 bits.
  assign w_sum_x = {in_x[COORD_W-1], in_x} + {r_off_x[COORD_W-1], r_off_x};
  assign w_sum_y = {in_y[COORD_W-1], in_y} + {r_off_y[COORD_W-1], r_off_y};

  always_comb begin
    w_cx     = r_s1_x[COORD_W-1:0];
    w_clip_x = 1'b0;
    if (r_s1_x[COORD_W]) begin
      w_cx     = '0;
      w_clip_x = 1'b1;
    end else if (r_s1_x > L_XMAX) begin
      w_cx     = L_XMAX[COORD_W-1:0];
      w_clip_x = 1'b1;
    end
  end

  always_comb begin
    w_cy     = r_s1_y[COORD_W-1:0];
    w_clip_y = 1'b0;
    if (r_s1_y[COORD_W]) begin
      w_cy     = '0;
      w_clip_y = 1'b1;
    end else if (r_s1_y > L_YMAX) begin
      w_cy     = L_YMAX[COORD_W-1:0];
      w_clip_y = 1'b1;
    end
  end

`ifdef POINT_TRANSLATOR_CLIP_DROP_EN
  // Out-of-range points vanish here; the output slot is simply not filled.
  assign w_s2_load  = r_s1_vld && !(w_clip_x || w_clip_y);
  assign w_clip_out = 1'b0;
`else
  assign w_s2_load  = r_s1_vld;
  assign w_clip_out = w_clip_x || w_clip_y;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_off_x <= '0;
      r_off_y <= '0;
    end else if (load_offset) begin
      r_off_x <= offset_x_in;
      r_off_y <= offset_y_in;
    end else if (frame_tick) begin
      r_off_x <= sat_add(r_off_x, vel_x);
      r_off_y <= sat_add(r_off_y, vel_y);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_vld <= 1'b0;
      r_s1_x   <= '0;
      r_s1_y   <= '0;
    end else if (w_s1_adv) begin
      r_s1_vld <= in_valid;
      if (in_valid) begin
        r_s1_x <= w_sum_x;
        r_s1_y <= w_sum_y;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_vld  <= 1'b0;
      r_out_x    <= '0;
      r_out_y    <= '0;
      r_out_clip <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_vld <= w_s2_load;
      if (w_s2_load) begin
        r_out_x    <= w_cx;
        r_out_y    <= w_cy;
        r_out_clip <= w_clip_out;
      end
    end
  end

  assign out_valid   = r_out_vld;
  assign out_x       = r_out_x;
  assign out_y       = r_out_y;
  assign out_clipped = r_out_clip;
  assign offset_x    = r_off_x;
  assign offset_y    = r_off_y;

endmodule

// File: tb/tb_point_translator.sv
`timescale 1ns/1ps
module tb_point_translator;
  localparam int CW = 12;
  localparam int VW = 5;
  localparam int XM = 1023;
  localparam int YM = 767;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 frame_tick = 1'b0;
  logic                 load_offset = 1'b0;
  logic signed [CW-1:0] offset_x_in = '0;
  logic signed [CW-1:0] offset_y_in = '0;
  logic signed [VW-1:0] vel_x = '0;
  logic signed [VW-1:0] vel_y = '0;
  logic                 in_valid = 1'b0;
  logic                 out_ready = 1'b0;
  logic signed [CW-1:0] in_x = '0;
  logic signed [CW-1:0] in_y = '0;
  logic                 in_ready, out_valid, out_clipped;
  logic [CW-1:0]        out_x, out_y;
  logic signed [CW-1:0] offset_x, offset_y;

  point_translator #(.COORD_W(CW), .VEL_W(VW), .X_MAX(XM), .Y_MAX(YM)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .load_offset(load_offset),
    .offset_x_in(offset_x_in), .offset_y_in(offset_y_in), .vel_x(vel_x), .vel_y(vel_y),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_clipped(out_clipped), .offset_x(offset_x), .offset_y(offset_y)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int delivered = 0;

  typedef struct { int x; int y; int clip; } pt_t;
  pt_t q[$];
  int m_off_x = 0;
  int m_off_y = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat_off(input int o, input int v);
    int s;
    s = o + v;
    if (s > 2047) s = 2047;
    if (s < -2048) s = -2048;
    return s;
  endfunction

  function automatic void clamp(input int s, input int mx, output int v, output int c);
    c = 0;
    v = s;
    if (s < 0) begin v = 0; c = 1; end
    else if (s > mx) begin v = mx; c = 1; end
  endfunction

  // Reference model: outputs must appear in acceptance order with the offset
  // in force at acceptance; offsets follow the load/tick rules.
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_offset_x", int'(offset_x), 0);
      chk("rst_offset_y", int'(offset_y), 0);
      q.delete();
      m_off_x = 0;
      m_off_y = 0;
    end else begin
      chk("offset_x", int'(offset_x), m_off_x);
      chk("offset_y", int'(offset_y), m_off_y);
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_beat", 1, 0);
        else begin
          chk("out_x", int'(out_x), q[0].x);
          chk("out_y", int'(out_y), q[0].y);
          chk("out_clipped", int'(out_clipped), q[0].clip);
        end
      end
`ifndef POINT_TRANSLATOR_CLIP_DROP_EN
      chk("in_ready", int'(in_ready), (q.size() == 2 && !out_ready) ? 0 : 1);
`endif
      if (out_valid && out_ready && q.size() > 0) begin
        void'(q.pop_front());
        delivered++;
      end
      if (in_valid && in_ready) begin
        pt_t p;
        int cx, cy;
        clamp(int'(in_x) + m_off_x, XM, p.x, cx);
        clamp(int'(in_y) + m_off_y, YM, p.y, cy);
        p.clip = cx | cy;
`ifdef POINT_TRANSLATOR_CLIP_DROP_EN
        if (p.clip == 0) q.push_back(p);
`else
        q.push_back(p);
`endif
      end
      if (load_offset) begin
        m_off_x = int'(offset_x_in);
        m_off_y = int'(offset_y_in);
      end else if (frame_tick) begin
        m_off_x = sat_off(m_off_x, int'(vel_x));
        m_off_y = sat_off(m_off_y, int'(vel_y));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int ox, input int oy);
    load_offset = 1'b1;
    offset_x_in = CW'(ox);
    offset_y_in = CW'(oy);
    cyc();
    load_offset = 1'b0;
  endtask

  task automatic chk_out(input string name, input int x, input int y, input int c);
    chk({name, "_valid"}, int'(out_valid), 1);
    chk({name, "_x"}, int'(out_x), x);
    chk({name, "_y"}, int'(out_y), y);
    chk({name, "_clip"}, int'(out_clipped), c);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int sent, start, n;
    repeat (3) cyc();
    reset = 1'b0;
    #1;
    chk("in_ready_after_reset", int'(in_ready), 1);
    out_ready = 1'b1;

    // Load (+100,-50), then stream two points; exact 2-cycle latency.
    load(100, -50);
    chk("load_off_x", int'(offset_x), 100);
    chk("load_off_y", int'(offset_y), -50);
    in_valid = 1'b1; in_x = 10; in_y = 60;
    cyc();
    in_x = 0; in_y = 0;
    chk("lat_cycle1_empty", int'(out_valid), 0);
    cyc();
    in_valid = 1'b0;
    chk_out("pt1", 110, 10, 0);
    cyc();
`ifdef POINT_TRANSLATOR_CLIP_DROP_EN
    chk("pt2_dropped", int'(out_valid), 0);
`else
    chk_out("pt2", 100, 0, 1);
`endif
    cyc();

    // Offset saturation in both directions.
    load(2040, 0);
    vel_x = 15; frame_tick = 1'b1;
    repeat (3) cyc();
    frame_tick = 1'b0;
    chk("sat_pos", int'(offset_x), 2047);
    load(-2040, 0);
    vel_x = -16; frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    chk("sat_neg", int'(offset_x), -2048);

    // Clamp at the upper bounds.
    load(100, 100);
    in_valid = 1'b1; in_x = 1000; in_y = 700;
    cyc();
    in_valid = 1'b0;
    cyc();
`ifdef POINT_TRANSLATOR_CLIP_DROP_EN
    chk("hi_dropped", int'(out_valid), 0);
`else
    chk_out("hi_clamp", 1023, 767, 1);
`endif

    // Negative x clamps to 0; the following point is unaffected.
    load(0, 0);
    in_valid = 1'b1; in_x = -5; in_y = 5;
    cyc();
    in_x = 3; in_y = 4;
    cyc();
    in_valid = 1'b0;
`ifdef POINT_TRANSLATOR_CLIP_DROP_EN
    chk("neg_dropped", int'(out_valid), 0);
`else
    chk_out("neg_clamp", 0, 5, 1);
`endif
    cyc();
    chk_out("after_neg", 3, 4, 0);

    // Load wins over a simultaneous frame tick.
    vel_x = 3; vel_y = 3; frame_tick = 1'b1;
    load(7, 0);
    frame_tick = 1'b0;
    chk("load_over_tick", int'(offset_x), 7);
    chk("load_over_tick_y", int'(offset_y), 0);

    // Eight back-to-back points with out_ready pattern 1,0,0,...
    sent = 0; start = delivered; n = 0;
    while ((sent < 8 || q.size() > 0 || out_valid) && n < 200) begin
      out_ready = (n % 3 == 0);
      in_valid  = (sent < 8);
      in_x = CW'(sent * 50);
      in_y = CW'(sent * 40);
      #1;
      if (in_valid && in_ready) sent++;
      cyc();
      n++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("b2b_budget", int'(n < 200), 1);
    chk("b2b_delivered", delivered - start, 8);
    cyc();

    // Reset with two points in flight: no stale beat afterwards.
    load(5, 6);
    out_ready = 1'b0;
    in_valid = 1'b1; in_x = 20; in_y = 20;
    cyc();
    in_x = 30;
    cyc();
    in_valid = 1'b0;
    chk("pipe_full_valid", int'(out_valid), 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_off_x", int'(offset_x), 0);
    chk("mid_rst_in_ready", int'(in_ready), 0);
    cyc();
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", int'(in_ready), 1);
    out_ready = 1'b1;
    start = delivered;
    repeat (4) cyc();
    chk("no_stale_beat", delivered - start, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_x        = CW'(int'($urandom_range(0, 1399)) - 200);
      in_y        = CW'(int'($urandom_range(0, 1099)) - 200);
      out_ready   = ($urandom_range(0, 3) != 0);
      load_offset = ($urandom_range(0, 29) == 0);
      offset_x_in = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(0, 4095))
                                                : CW'(int'($urandom_range(0, 400)) - 200);
      offset_y_in = CW'(int'($urandom_range(0, 400)) - 200);
      frame_tick  = ($urandom_range(0, 7) == 0);
      vel_x       = VW'($urandom_range(0, 31));
      vel_y       = VW'($urandom_range(0, 31));
      cyc();
    end
    in_valid = 1'b0; load_offset = 1'b0; frame_tick = 1'b0; out_ready = 1'b1;
    repeat (5) cyc();
    chk("drain_empty", q.size(), 0);
    chk("random_traffic_seen", int'(delivered > 300), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
